mem_arb2: RTL and testbench

Two-requester round-robin arbiter and sequencer for the single-port `memdes` memory. It accepts independent read/write requests from two masters, grants one at a time, and drives the memory's valid/ready command port. It holds each command until the memory completes it, returns read data to the granted master, and aborts any access the memory does not complete within a bounded number of cycles. It sits directly in front of `memdes`, so two front-door agents can share one memory.

---
 rtl/mem_arb2.sv | 164 ++++++++++++++++
 tb/tb_mem_arb2.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arb2.sv
// mem_arb2: two-master round-robin arbiter and sequencer
// in front of the single-port memdes memory.
module mem_arb2 #(
  parameter int ADDRWIDTH = 4,
  parameter int DATAWIDTH = 16,
  parameter int TIMEOUT   = 15
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 req0_valid_i,
  input  logic                 req0_wr_i,
  input  logic [ADDRWIDTH-1:0] req0_addr_i,
  input  logic [DATAWIDTH-1:0] req0_wdata_i,
  output logic                 req0_ready_o,
  output logic                 req0_err_o,
  output logic [DATAWIDTH-1:0] req0_rdata_o,
  input  logic                 req1_valid_i,
  input  logic                 req1_wr_i,
  input  logic [ADDRWIDTH-1:0] req1_addr_i,
  input  logic [DATAWIDTH-1:0] req1_wdata_i,
  output logic                 req1_ready_o,
  output logic                 req1_err_o,
  output logic [DATAWIDTH-1:0] req1_rdata_o,
  output logic                 mem_valid_o,
  output logic                 mem_wr_en_o,
  output logic                 mem_rd_en_o,
  output logic [ADDRWIDTH-1:0] mem_addr_o,
  output logic [DATAWIDTH-1:0] mem_wdata_o,
  input  logic [DATAWIDTH-1:0] mem_rdata_i,
  input  logic                 mem_ready_i,
  output logic [1:0]           grant_o
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_RESP
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic                 r_prio;
  logic [1:0]           r_grant;
  logic                 r_wr;
  logic [ADDRWIDTH-1:0] r_addr;
  logic [DATAWIDTH-1:0] r_wdata;
  logic                 r_err;
  logic [CW-1:0]        r_cnt;
  logic [DATAWIDTH-1:0] r_rdata0;
  logic [DATAWIDTH-1:0] r_rdata1;

  logic w_any;
  logic w_pick1;
  logic w_last;

  assign w_any   = req0_valid_i | req1_valid_i;
  // master 1 wins when alone, or when both ask and it holds priority
  assign w_pick1 = req1_valid_i & (~req0_valid_i | r_prio);
  assign w_last  = (r_cnt == CNT_LAST);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    mem_valid_o  = 1'b0;
    mem_wr_en_o  = 1'b0;
    mem_rd_en_o  = 1'b0;
    req0_ready_o = 1'b0;
    req0_err_o   = 1'b0;
    req1_ready_o = 1'b0;
    req1_err_o   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_any) begin
          w_state_nxt = S_ACCESS;
        end
      end
      S_ACCESS: begin
        mem_valid_o = 1'b1;
        mem_wr_en_o = r_wr;
        mem_rd_en_o = ~r_wr;
        if (mem_ready_i || w_last) begin
          w_state_nxt = S_RESP;
        end
      end
      S_RESP: begin
        req0_ready_o = r_grant[0];
        req0_err_o   = r_grant[0] & r_err;
        req1_ready_o = r_grant[1];
        req1_err_o   = r_grant[1] & r_err;
        w_state_nxt  = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_prio   <= 1'b0;
      r_grant  <= 2'b00;
      r_wr     <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_err    <= 1'b0;
      r_cnt    <= '0;
      r_rdata0 <= '0;
      r_rdata1 <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_grant <= w_pick1 ? 2'b10 : 2'b01;
            r_prio  <= ~w_pick1;
            r_wr    <= w_pick1 ? req1_wr_i : req0_wr_i;
            r_addr  <= w_pick1 ? req1_addr_i : req0_addr_i;
            r_wdata <= w_pick1 ? req1_wdata_i : req0_wdata_i;
            r_cnt   <= '0;
          end
        end
        S_ACCESS: begin
          // a ready in the final cycle beats the timeout
          if (mem_ready_i) begin
            r_err <= 1'b0;
            if (r_grant[1]) begin
              r_rdata1 <= mem_rdata_i;
            end else begin
              r_rdata0 <= mem_rdata_i;
            end
          end else if (w_last) begin
            r_err <= 1'b1;
          end else if (r_cnt != '1) begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
        S_RESP: begin
          r_grant <= 2'b00;
        end
        default: begin
          r_grant <= 2'b00;
        end
      endcase
    end
  end

  assign mem_addr_o   = r_addr;
  assign mem_wdata_o  = r_wdata;
  assign req0_rdata_o = r_rdata0;
  assign req1_rdata_o = r_rdata1;
  assign grant_o      = r_grant;

endmodule

// File: tb/tb_mem_arb2.sv
// tb_mem_arb2: directed self-checking bench for mem_arb2
// with a behavioural memdes responder.
module tb_mem_arb2;

  logic        clk_i;
  logic        rst_i;
  logic        req0_valid_i;
  logic        req0_wr_i;
  logic [3:0]  req0_addr_i;
  logic [15:0] req0_wdata_i;
  logic        req0_ready_o;
  logic        req0_err_o;
  logic [15:0] req0_rdata_o;
  logic        req1_valid_i;
  logic        req1_wr_i;
  logic [3:0]  req1_addr_i;
  logic [15:0] req1_wdata_i;
  logic        req1_ready_o;
  logic        req1_err_o;
  logic [15:0] req1_rdata_o;
  logic        mem_valid_o;
  logic        mem_wr_en_o;
  logic        mem_rd_en_o;
  logic [3:0]  mem_addr_o;
  logic [15:0] mem_wdata_o;
  logic [15:0] mem_rdata_i;
  logic        mem_ready_i;
  logic [1:0]  grant_o;

  mem_arb2 dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .req0_valid_i (req0_valid_i),
    .req0_wr_i    (req0_wr_i),
    .req0_addr_i  (req0_addr_i),
    .req0_wdata_i (req0_wdata_i),
    .req0_ready_o (req0_ready_o),
    .req0_err_o   (req0_err_o),
    .req0_rdata_o (req0_rdata_o),
    .req1_valid_i (req1_valid_i),
    .req1_wr_i    (req1_wr_i),
    .req1_addr_i  (req1_addr_i),
    .req1_wdata_i (req1_wdata_i),
    .req1_ready_o (req1_ready_o),
    .req1_err_o   (req1_err_o),
    .req1_rdata_o (req1_rdata_o),
    .mem_valid_o  (mem_valid_o),
    .mem_wr_en_o  (mem_wr_en_o),
    .mem_rd_en_o  (mem_rd_en_o),
    .mem_addr_o   (mem_addr_o),
    .mem_wdata_o  (mem_wdata_o),
    .mem_rdata_i  (mem_rdata_i),
    .mem_ready_i  (mem_ready_i),
    .grant_o      (grant_o)
  );

  int n_chk = 0;
  int n_err = 0;

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // memory responder: ready after mem_lat waiting cycles, or never when hang
  logic [15:0] mem [16];
  int          mem_lat = 0;
  bit          hang = 0;
  int          wait_cnt = 0;

  always @(posedge clk_i) begin
    #1;
    if (mem_ready_i) begin
      mem_ready_i = 1'b0;
    end else if (mem_valid_o && !hang) begin
      if (wait_cnt == mem_lat) begin
        if (mem_wr_en_o) mem[mem_addr_o] = mem_wdata_o;
        mem_rdata_i = mem[mem_addr_o];
        mem_ready_i = 1'b1;
        wait_cnt = 0;
      end else begin
        wait_cnt++;
      end
    end else begin
      wait_cnt = 0;
    end
  end

  // bus monitor
  int         vcnt, bursts, r0cnt, r1cnt;
  int         bad_strobe = 0;
  int         addr_chg = 0;
  bit         saw_wr, saw_rd, prev_valid;
  logic [3:0] last_addr, prev_addr;
  logic [1:0] prev_grant = 2'b00;
  logic [1:0] g_log[$];

  always @(negedge clk_i) begin
    if (mem_valid_o) begin
      vcnt++;
      if (!prev_valid) bursts++;
      else if (mem_addr_o != prev_addr) addr_chg++;
      if (mem_wr_en_o == mem_rd_en_o) bad_strobe++;
      saw_wr = saw_wr | mem_wr_en_o;
      saw_rd = saw_rd | mem_rd_en_o;
      last_addr = mem_addr_o;
    end else if (mem_wr_en_o || mem_rd_en_o) begin
      bad_strobe++;
    end
    prev_valid = mem_valid_o;
    prev_addr = mem_addr_o;
    if (req0_ready_o) r0cnt++;
    if (req1_ready_o) r1cnt++;
    if (grant_o != 2'b00 && prev_grant == 2'b00) g_log.push_back(grant_o);
    prev_grant = grant_o;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clr_mon();
    vcnt = 0; bursts = 0; r0cnt = 0; r1cnt = 0;
    saw_wr = 0; saw_rd = 0; last_addr = 4'h0;
    g_log.delete();
  endtask

  task automatic set_req(input int m, input logic wr,
                         input logic [3:0] a, input logic [15:0] d);
    if (m == 0) begin
      req0_wr_i = wr; req0_addr_i = a; req0_wdata_i = d; req0_valid_i = 1'b1;
    end else begin
      req1_wr_i = wr; req1_addr_i = a; req1_wdata_i = d; req1_valid_i = 1'b1;
    end
  endtask

  task automatic drop_req(input int m);
    if (m == 0) req0_valid_i = 1'b0;
    else req1_valid_i = 1'b0;
  endtask

  // waits for master m's ready pulse, then returns at posedge+1
  task automatic wait_ready(input int m, output logic [15:0] rd,
                            output logic er);
    bit got = 0;
    rd = 16'hxxxx;
    er = 1'bx;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk_i);
      if ((m == 0) ? req0_ready_o : req1_ready_o) begin
        got = 1;
        rd = (m == 0) ? req0_rdata_o : req1_rdata_o;
        er = (m == 0) ? req0_err_o : req1_err_o;
      end
    end
    chk($sformatf("ready_m%0d_seen", m), 32'(got), 32'd1);
    @(posedge clk_i);
    #1;
  endtask

  logic [15:0] rd;
  logic        er;
  logic [15:0] exp_d [16];
  bit          got;

  initial begin
    rst_i = 1'b1;
    req0_valid_i = 0; req0_wr_i = 0; req0_addr_i = '0; req0_wdata_i = '0;
    req1_valid_i = 0; req1_wr_i = 0; req1_addr_i = '0; req1_wdata_i = '0;
    mem_rdata_i = '0;
    mem_ready_i = 1'b0;
    for (int i = 0; i < 16; i++) mem[i] = 16'h0000;

    // reset state
    repeat (2) @(negedge clk_i);
    chk("rst_strobes", {29'd0, mem_valid_o, mem_wr_en_o, mem_rd_en_o}, 32'd0);
    chk("rst_grant", 32'(grant_o), 32'd0);
    chk("rst_ready", {28'd0, req0_ready_o, req0_err_o, req1_ready_o, req1_err_o}, 32'd0);
    chk("rst_rdata", {req0_rdata_o, req1_rdata_o}, 32'd0);
    chk("rst_addr", {12'd0, mem_addr_o, mem_wdata_o}, 32'd0);
    rst_i = 1'b0;
    @(posedge clk_i);
    #1;
    clr_mon();

    // single write, memory answers 2 cycles after valid
    mem_lat = 2;
    set_req(0, 1'b1, 4'd3, 16'hA5A5);
    wait_ready(0, rd, er);
    drop_req(0);
    repeat (2) @(posedge clk_i);
    #1;
    chk("wr_err", 32'(er), 32'd0);
    chk("wr_bursts", 32'(bursts), 32'd1);
    chk("wr_valid_cycles", 32'(vcnt), 32'd3);
    chk("wr_addr", 32'(last_addr), 32'd3);
    chk("wr_strobe", {30'd0, saw_wr, saw_rd}, 32'b10);
    chk("wr_pulses", 32'(r0cnt), 32'd1);
    chk("wr_mem", 32'(mem[3]), 32'hA5A5);

    // read-back by master 1
    clr_mon();
    mem_lat = 0;
    set_req(1, 1'b0, 4'd3, 16'h0000);
    wait_ready(1, rd, er);
    drop_req(1);
    chk("rd_data", 32'(rd), 32'hA5A5);
    chk("rd_err", 32'(er), 32'd0);
    chk("rd_strobe", {30'd0, saw_wr, saw_rd}, 32'b01);
    chk("rd_valid_cycles", 32'(vcnt), 32'd1);
    repeat (3) @(negedge clk_i);
    chk("rd_hold", 32'(req1_rdata_o), 32'hA5A5);
    chk("rd_ready_low", {30'd0, req1_ready_o, req1_err_o}, 32'd0);

    // contention from reset: both masters keep requesting
    @(posedge clk_i);
    #2 rst_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
    @(posedge clk_i);
    #1;
    clr_mon();
    set_req(0, 1'b1, 4'd8, 16'h0808);
    set_req(1, 1'b0, 4'd3, 16'h0000);
    got = 0;
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clk_i);
      #1;
      if (r0cnt + r1cnt >= 4) got = 1;
    end
    chk("cont_done", 32'(got), 32'd1);
    @(posedge clk_i);
    #1;
    drop_req(0);
    drop_req(1);
    repeat (3) @(posedge clk_i);
    #1;
    chk("cont_ngrants", 32'(g_log.size()), 32'd4);
    if (g_log.size() >= 4) begin
      chk("cont_g0", 32'(g_log[0]), 32'b01);
      chk("cont_g1", 32'(g_log[1]), 32'b10);
      chk("cont_g2", 32'(g_log[2]), 32'b01);
      chk("cont_g3", 32'(g_log[3]), 32'b10);
    end
    chk("cont_r0", 32'(r0cnt), 32'd2);
    chk("cont_r1", 32'(r1cnt), 32'd2);

    // timeout: memory never answers
    clr_mon();
    hang = 1;
    set_req(0, 1'b0, 4'd7, 16'h0000);
    wait_ready(0, rd, er);
    drop_req(0);
    chk("to_err", 32'(er), 32'd1);
    chk("to_valid_cycles", 32'(vcnt), 32'd15);
    chk("to_pulses", 32'(r0cnt), 32'd1);
    hang = 0;

    // next request after a timeout proceeds normally
    @(posedge clk_i);
    #1;
    clr_mon();
    set_req(0, 1'b1, 4'd5, 16'h1234);
    wait_ready(0, rd, er);
    drop_req(0);
    chk("post_to_err", 32'(er), 32'd0);
    chk("post_to_valid", 32'(vcnt), 32'd1);

    // ready in the very last cycle wins over timeout
    @(posedge clk_i);
    #1;
    clr_mon();
    mem_lat = 14;
    set_req(0, 1'b0, 4'd5, 16'h0000);
    wait_ready(0, rd, er);
    drop_req(0);
    chk("last_err", 32'(er), 32'd0);
    chk("last_data", 32'(rd), 32'h1234);
    chk("last_valid_cycles", 32'(vcnt), 32'd15);
    mem_lat = 0;

    // reset in the middle of an access (prio currently points at master 1)
    @(posedge clk_i);
    #1;
    clr_mon();
    hang = 1;
    set_req(0, 1'b0, 4'd3, 16'h0000);
    repeat (3) @(posedge clk_i);
    #2;
    chk("mid_pre_valid", 32'(mem_valid_o), 32'd1);
    rst_i = 1'b1;
    #1;
    chk("mid_strobes", {29'd0, mem_valid_o, mem_wr_en_o, mem_rd_en_o}, 32'd0);
    chk("mid_grant", 32'(grant_o), 32'd0);
    chk("mid_addr", 32'(mem_addr_o), 32'd0);
    drop_req(0);
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
    hang = 0;
    chk("mid_no_pulse", 32'(r0cnt), 32'd0);
    @(posedge clk_i);
    #1;
    set_req(0, 1'b0, 4'd3, 16'h0000);
    set_req(1, 1'b0, 4'd5, 16'h0000);
    got = 0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk_i);
      if (grant_o != 2'b00) got = 1;
    end
    chk("mid_first_grant", 32'(grant_o), 32'b01);
    wait_ready(0, rd, er);
    drop_req(0);
    chk("mid_m0_data", 32'(rd), 32'hA5A5);
    wait_ready(1, rd, er);
    drop_req(1);
    chk("mid_m1_data", 32'(rd), 32'h1234);

    // full sweep: master 0 writes, master 1 reads back
    for (int i = 0; i < 16; i++) begin
      exp_d[i] = 16'($urandom);
      mem_lat = i % 3;
      set_req(0, 1'b1, 4'(i), exp_d[i]);
      wait_ready(0, rd, er);
      drop_req(0);
      chk($sformatf("sweep_wr_err_%0d", i), 32'(er), 32'd0);
    end
    for (int i = 0; i < 16; i++) begin
      mem_lat = (i + 1) % 3;
      set_req(1, 1'b0, 4'(i), 16'h0000);
      wait_ready(1, rd, er);
      drop_req(1);
      chk($sformatf("sweep_rd_%0d", i), 32'(rd), 32'(exp_d[i]));
      chk($sformatf("sweep_rd_err_%0d", i), 32'(er), 32'd0);
    end

    repeat (2) @(posedge clk_i);
    #1;
    chk("strobe_exclusive", 32'(bad_strobe), 32'd0);
    chk("addr_stable", 32'(addr_chg), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
